// File: rtl/risac_ibus_prefetch.sv
// Purpose : sequential instruction prefetch buffer between the core fetch port (avs_*) and instruction memory (avm_*).
// Latency : a fetch that hits the FIFO head completes in 0 cycles; a redirect returns data 2 cycles after the miss cycle, plus 1 per memory wait cycle.
// Backpr. : the core is stalled via avs_waitrequest; the memory stalls us via avm_waitrequest, and no read is issued while the FIFO is full.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   avs_address/avs_read        core fetch request (byte address, bits [1:0] ignored)
//   avs_readdata                head instruction word (0 while the buffer is empty)
//   avs_waitrequest             stalls the core while a request is not a hit
//   avm_address/avm_read        memory read request, driven from registered state
//   avm_readdata                memory data, taken in the cycle the read is accepted
//   avm_waitrequest             memory stall; the request is held while it is high
module risac_ibus_prefetch #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] C_FULL = (PW + 1)'(DEPTH);

    // Buffer storage and its bookkeeping.
    logic [31:0] r_data [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;

    // Address of the word at the FIFO head (what the core must ask for to hit).
    logic [31:0] r_head_addr;
    // Address currently presented to memory.
    logic [31:0] r_fetch_addr;
    // A redirect that arrived while a memory read was stalled; the stalled
    // read must still complete unchanged, so the new target waits here.
    logic        r_redir_pend;
    logic [31:0] r_redir_addr;

    logic [31:0] w_target;
    logic        w_empty;
    logic        w_not_full;
    logic        w_head_match;
    logic        w_avm_read;
    logic        w_hit;
    logic        w_miss;
    logic        w_accept;
    logic        w_stalled;
    logic        w_push;
    logic        w_pop;

    assign w_target     = avs_address & ~32'd3;
    assign w_empty      = (r_count == '0);
    assign w_not_full   = (r_count != C_FULL);
    assign w_head_match = (w_target == r_head_addr);

    // Gating with rst_n makes the request drop the instant reset is asserted,
    // rather than waiting for the register reset to propagate.
    assign w_avm_read = rst_n & (w_not_full | r_redir_pend);

    assign w_hit     = avs_read & ~w_empty & w_head_match;
    // An empty buffer whose head address matches is a refill wait, not a miss.
    assign w_miss    = avs_read & ~w_head_match;
    assign w_accept  = w_avm_read & ~avm_waitrequest;
    assign w_stalled = w_avm_read & avm_waitrequest;
    // Data accepted during a miss or while a redirect is pending belongs to
    // the abandoned stream and is discarded.
    assign w_push    = w_accept & ~r_redir_pend & ~w_miss;
    assign w_pop     = w_hit;

    assign avm_address     = r_fetch_addr;
    assign avm_read        = w_avm_read;
    assign avs_waitrequest = avs_read & ~w_hit;
    assign avs_readdata    = w_empty ? 32'd0 : r_data[r_rd_ptr];

    // Storage needs no reset: an empty buffer never exposes its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= avm_readdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_head_addr  <= RESET_ADDR;
            r_fetch_addr <= RESET_ADDR;
            r_redir_pend <= 1'b0;
            r_redir_addr <= 32'd0;
        end else if (w_miss) begin
            // Flush and retarget the whole stream at the new fetch address.
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_head_addr <= w_target;
            if (w_stalled) begin
                // Memory still owns the current request: keep avm_address
                // steady and remember where to go once it is accepted.
                r_redir_pend <= 1'b1;
                r_redir_addr <= w_target;
            end else begin
                r_fetch_addr <= w_target;
                r_redir_pend <= 1'b0;
            end
        end else begin
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_head_addr <= r_head_addr + 32'd4;
            end

            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_fetch_addr <= r_fetch_addr + 32'd4;
            end else if (r_redir_pend && w_accept) begin
                // The stale read just completed; start the new stream.
                r_fetch_addr <= r_redir_addr;
                r_redir_pend <= 1'b0;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_risac_ibus_prefetch.sv
module tb_risac_ibus_prefetch;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_A  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] avs_address = 32'd0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    risac_ibus_prefetch #(.DEPTH(DEPTH), .RESET_ADDR(RST_A)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .avs_waitrequest(avs_waitrequest),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return ((a & ~32'd3) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign avm_readdata = avm_waitrequest ? 32'hDEAD_BEEF : mem_f(avm_address);

    // Reference model: the buffer as a queue of words plus the stream addresses.
    logic [31:0] q[$];
    logic [31:0] m_head;
    logic [31:0] m_fetch;
    logic [31:0] m_redir;
    bit          m_rp;

    // Values seen at the last sampled cycle.
    logic        last_wait = 1'b0;
    logic [31:0] last_rdata;
    logic        last_avm_read;
    logic [31:0] last_avm_addr;
    int          n_acc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_head  = RST_A;
        m_fetch = RST_A;
        m_redir = 32'd0;
        m_rp    = 1'b0;
    endtask

    // One clock cycle: drive inputs, sample and check mid-cycle, advance model.
    // Entered and left just after a rising edge.
    task automatic step(input logic rd, input logic [31:0] a, input logic mw);
        logic [31:0] ta;
        logic        e_rd, hit, miss, acc;
        avs_read        = rd;
        avs_address     = a;
        avm_waitrequest = mw;
        @(negedge clk);
        ta   = a & ~32'd3;
        e_rd = (q.size() < DEPTH) || m_rp;
        hit  = rd && (q.size() != 0) && (ta == m_head);
        miss = rd && (ta != m_head);
        acc  = e_rd && !mw;

        last_wait     = avs_waitrequest;
        last_rdata    = avs_readdata;
        last_avm_read = avm_read;
        last_avm_addr = avm_address;
        if (avm_read && !mw) n_acc++;

        chk("avm_read", {31'd0, avm_read}, {31'd0, e_rd});
        chk("avm_address", avm_address, m_fetch);
        chk("avs_waitrequest", {31'd0, avs_waitrequest}, {31'd0, rd && !hit});
        chk("avs_readdata", avs_readdata, (q.size() != 0) ? q[0] : 32'd0);
        if (rd && !avs_waitrequest) chk("hit_data_vs_mem", avs_readdata, mem_f(ta));

        if (miss) begin
            q.delete();
            m_head = ta;
            if (e_rd && mw) begin
                m_rp    = 1'b1;
                m_redir = ta;
            end else begin
                m_fetch = ta;
                m_rp    = 1'b0;
            end
        end else begin
            if (hit) begin
                void'(q.pop_front());
                m_head = m_head + 32'd4;
            end
            if (acc) begin
                if (m_rp) begin
                    m_fetch = m_redir;
                    m_rp    = 1'b0;
                end else begin
                    q.push_back(mem_f(m_fetch));
                    m_fetch = m_fetch + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Core fetch obeying the hold rule; reports stall cycles and the word.
    task automatic fetch(input logic [31:0] a, output int stalls, output logic [31:0] d);
        bit done = 1'b0;
        stalls = 0;
        d = 32'd0;
        for (int k = 0; k < 40 && !done; k++) begin
            step(1'b1, a, 1'b0);
            if (!last_wait) begin
                done   = 1'b1;
                stalls = k;
                d      = last_rdata;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fetch_timeout: addr %h got no data within 40 cycles", a);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        avs_read = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        last_wait = 1'b0;
        n_acc     = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        int          tot;
        logic [31:0] d;
        logic        cur_rd;
        logic [31:0] cur_a;
        logic        mw;

        model_reset();
        @(posedge clk);
        #1;
        chk("reset_avm_read_low", {31'd0, avm_read}, 32'd0);
        chk("reset_readdata", avs_readdata, 32'd0);
        do_reset();

        // Sequential stream: one fill cycle, then a word every cycle.
        fetch(32'h0, s, d);
        chk("t1_first_stalls", s, 32'd1);
        chk("t1_first_data", d, 32'h5A5A_1234);
        tot = 0;
        for (int i = 1; i < 16; i++) begin
            fetch(32'(i * 4), s, d);
            tot += s;
        end
        chk("t1_stream_stalls", tot, 32'd0);

        // Branch to 0x100 after two words.
        do_reset();
        fetch(32'h0, s, d);
        fetch(32'h4, s, d);
        fetch(32'h100, s, d);
        chk("t2_branch_stalls", s, 32'd2);
        chk("t2_branch_data", d, mem_f(32'h100));
        fetch(32'h104, s, d);
        chk("t2_after_stalls", s, 32'd0);

        // Redirect while memory stalls the read of 0x10.
        do_reset();
        fetch(32'h0, s, d);
        fetch(32'h4, s, d);
        fetch(32'h8, s, d);
        step(1'b1, 32'h200, 1'b1);
        chk("t3_addr_at_miss", last_avm_addr, 32'h10);
        step(1'b1, 32'h200, 1'b1);
        chk("t3_addr_held", last_avm_addr, 32'h10);
        chk("t3_read_held", {31'd0, last_avm_read}, 32'd1);
        step(1'b1, 32'h200, 1'b0);
        chk("t3_addr_accept", last_avm_addr, 32'h10);
        step(1'b1, 32'h200, 1'b0);
        chk("t3_addr_redirected", last_avm_addr, 32'h200);
        fetch(32'h200, s, d);
        chk("t3_data", d, mem_f(32'h200));

        // Idle core: exactly DEPTH reads, then one hit frees one slot.
        do_reset();
        repeat (8) step(1'b0, 32'h0, 1'b0);
        chk("t4_reads_issued", n_acc, 32'd4);
        chk("t4_read_off_full", {31'd0, last_avm_read}, 32'd0);
        fetch(32'h0, s, d);
        chk("t4_hit_stalls", s, 32'd0);
        step(1'b0, 32'h0, 1'b0);
        chk("t4_read_reenabled", {31'd0, last_avm_read}, 32'd1);
        step(1'b0, 32'h0, 1'b0);
        chk("t4_read_off_again", {31'd0, last_avm_read}, 32'd0);
        chk("t4_reads_total", n_acc, 32'd5);

        // Two redirects stacked behind one stalled read.
        do_reset();
        step(1'b1, 32'h40, 1'b1);
        step(1'b1, 32'h80, 1'b1);
        fetch(32'h80, s, d);
        chk("t5_stalls", s, 32'd2);
        chk("t5_data", d, mem_f(32'h80));

        // Reset in the middle of filling.
        do_reset();
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_read_drops", {31'd0, avm_read}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n     = 1'b1;
        last_wait = 1'b0;
        fetch(32'h0, s, d);
        chk("t6_restart_stalls", s, 32'd1);
        chk("t6_restart_data", d, mem_f(32'h0));

        // Random traffic against the model.
        do_reset();
        cur_rd = 1'b0;
        cur_a  = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            if (!(cur_rd && last_wait)) begin
                int r = $urandom_range(0, 99);
                if (r < 65) begin
                    cur_rd = 1'b1;
                    cur_a  = {cur_a[31:2] + 30'd1, 2'($urandom_range(0, 3))};
                end else if (r < 80) begin
                    cur_rd = 1'b1;
                    if ($urandom_range(0, 3) == 0)
                        cur_a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 3) << 2);
                    else
                        cur_a = 32'($urandom_range(0, 255)) << 2;
                end else begin
                    cur_rd = 1'b0;
                end
            end
            mw = ($urandom_range(0, 9) < 3);
            step(cur_rd, cur_a, mw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
